inst_dispatch: RTL and testbench

//  Downstream of the Core sequencer: consumes its pc/inst_valid and returns inst_done.
//  Per instruction:
//   - fetches a 16-bit microinstruction from the sync program ROM at {mode, pc}
//   - decodes it and issues a start pulse to one Frodo functional unit (matrix mul, SHAKE, sampler, ...)
//   - waits for that unit's done, then pulses inst_done back to the Core.

---
 rtl/inst_dispatch_pkg.sv | 19 +
 rtl/dispatch_wdt.sv | 22 ++
 rtl/inst_dispatch.sv | 97 +++++++++
 tb/tb_inst_dispatch.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/inst_dispatch_pkg.sv
// inst_dispatch_pkg: shared Frodo microinstruction format, unit ids, mode codes and dispatcher states.
package inst_dispatch_pkg;
    localparam logic [3:0] NOP_ID       = 4'hF;
    localparam logic [3:0] UNIT_MATMUL  = 4'h0;
    localparam logic [3:0] UNIT_SHAKE   = 4'h1;
    localparam logic [3:0] UNIT_SAMPLER = 4'h2;
    localparam logic [3:0] UNIT_PACK    = 4'h3;
    localparam logic [1:0] MODE_KEYGEN  = 2'b00;
    localparam logic [1:0] MODE_ENCAP   = 2'b01;
    localparam logic [1:0] MODE_DECAP   = 2'b10;
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_WAIT, S_DONE
    } state_t;
    typedef struct packed {
        logic [3:0] unit;
        logic [3:0] op;
        logic [7:0] arg;
    } inst_t;
endpackage

// File: rtl/dispatch_wdt.sv
// dispatch_wdt: WAIT-state watchdog counter with expiry flag; only built when DISPATCH_WDT_EN is defined.
`ifdef DISPATCH_WDT_EN
module dispatch_wdt #(
    parameter int WDT_CYC = 4096
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    input  logic run,
    output logic expired
);
    logic [12:0] cnt_q, cnt_d;
    always_comb begin
        cnt_d   = clr ? '0 : run ? cnt_q + 13'd1 : cnt_q;
        expired = run && (cnt_q == 13'(WDT_CYC - 1));
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
endmodule
`endif

// File: rtl/inst_dispatch.sv
// inst_dispatch: fetches a ROM microinstruction per Core request, starts one functional unit and reports completion.
// Optional WAIT watchdog enabled with DISPATCH_WDT_EN.
module inst_dispatch
    import inst_dispatch_pkg::*;
#(
    parameter int NUM_UNITS = 4,
    parameter int ADDR_W    = 10,
    parameter int WDT_CYC   = 4096
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 inst_valid,
    input  logic [7:0]           pc,
    input  logic [1:0]           mode,
    input  logic [1:0]           level,
    output logic [ADDR_W-1:0]    rom_addr,
    input  logic [15:0]          rom_data,
    output logic [NUM_UNITS-1:0] unit_start,
    output logic [3:0]           unit_op,
    output logic [7:0]           unit_arg,
    output logic [1:0]           unit_level,
    input  logic [NUM_UNITS-1:0] unit_done,
    output logic                 inst_done,
    output logic                 busy,
    output logic [1:0]           err
);
    state_t state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [1:0] mode_q, mode_d, level_q, level_d, err_q, err_d;
    inst_t inst_q, inst_d, dec;
    logic [NUM_UNITS-1:0] sel;
    logic req, bad_id, hit, wdt_exp;
    assign dec    = inst_t'(rom_data);
    assign req    = (state_q == S_IDLE) && inst_valid;
    assign bad_id = (dec.unit != NOP_ID) && (32'(dec.unit) >= NUM_UNITS);
    assign sel    = NUM_UNITS'(1) << inst_q.unit;
    assign hit    = |(unit_done & sel);
`ifdef DISPATCH_WDT_EN
    dispatch_wdt #(.WDT_CYC(WDT_CYC)) u_wdt (
        .clk     (clk),
        .rstn    (rstn),
        .clr     (state_q == S_ISSUE),
        .run     (state_q == S_WAIT),
        .expired (wdt_exp)
    );
`else
    assign wdt_exp = 1'b0;
`endif
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= S_IDLE;
        else       state_q <= state_d;
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = inst_valid ? S_FETCH : S_IDLE;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: state_d = (dec.unit == NOP_ID || bad_id) ? S_DONE : S_ISSUE;
            S_ISSUE:  state_d = S_WAIT;
            S_WAIT:   state_d = (hit || wdt_exp) ? S_DONE : S_WAIT;
            default:  state_d = S_IDLE;
        endcase
    end
    always_comb begin
        pc_d    = req ? pc : pc_q;
        mode_d  = req ? mode : mode_q;
        level_d = req ? level : level_q;
        inst_d  = (state_q == S_DECODE) ? dec : inst_q;
        err_d   = err_q | {wdt_exp && !hit,
                           (inst_valid && state_q != S_IDLE) || (state_q == S_DECODE && bad_id)};
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc_q    <= '0;
            mode_q  <= '0;
            level_q <= '0;
            inst_q  <= '0;
            err_q   <= '0;
        end else begin
            pc_q    <= pc_d;
            mode_q  <= mode_d;
            level_q <= level_d;
            inst_q  <= inst_d;
            err_q   <= err_d;
        end
    end
    always_comb begin
        rom_addr   = ADDR_W'({mode_q, pc_q});
        unit_start = (state_q == S_ISSUE) ? sel : '0;
        unit_op    = inst_q.op;
        unit_arg   = inst_q.arg;
        unit_level = level_q;
        inst_done  = state_q == S_DONE;
        busy       = state_q != S_IDLE;
        err        = err_q;
    end
endmodule

// File: tb/tb_inst_dispatch.sv
// tb_inst_dispatch: scoreboard bench for inst_dispatch with a behavioural sync ROM and functional-unit model.
module tb_inst_dispatch;
    import inst_dispatch_pkg::*;
    localparam int NU = 4;
    localparam int WDT = 16;
    typedef struct {
        logic [3:0] mask;
        logic [3:0] op;
        logic [7:0] arg;
        logic [1:0] lv;
    } sb_t;
    logic clk = 0, rstn = 0, inst_valid = 0;
    logic [7:0] pc = 0;
    logic [1:0] mode = 0, level = 0;
    logic [9:0] rom_addr, rom_addr_exp = 0;
    logic [15:0] rom_data = 0, rom_word = 0;
    logic [NU-1:0] unit_start, unit_done = 0;
    logic [3:0] unit_op;
    logic [7:0] unit_arg;
    logic [1:0] unit_level, err;
    logic inst_done, busy;
    int checks = 0, failures = 0;
    sb_t sb_q[$];
    inst_dispatch #(.NUM_UNITS(NU), .ADDR_W(10), .WDT_CYC(WDT)) dut (
        .clk(clk), .rstn(rstn), .inst_valid(inst_valid), .pc(pc), .mode(mode), .level(level),
        .rom_addr(rom_addr), .rom_data(rom_data), .unit_start(unit_start), .unit_op(unit_op),
        .unit_arg(unit_arg), .unit_level(unit_level), .unit_done(unit_done),
        .inst_done(inst_done), .busy(busy), .err(err)
    );
    always #5 clk = ~clk;
    // Sync ROM: returns the programmed word only for the address the Core request should produce.
    always @(posedge clk) rom_data <= (rom_addr == rom_addr_exp) ? rom_word : 16'hE000;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic run_inst(input logic [1:0] m, input logic [7:0] p, input logic [1:0] lv,
                            input logic [15:0] w, input int dly, input bit mid_req,
                            input bit lost, input int exp_done_n);
        int start_n = -1, done_n = -1, starts = 0, exp_starts;
        bit stable = 1;
        sb_t e;
        logic [3:0] mask;
        mask = 4'(1) << w[15:12];
        exp_starts = (w[15:12] < 4'(NU)) ? 1 : 0;
        rom_word = w;
        rom_addr_exp = {m, p};
        if (exp_starts == 1) sb_q.push_back('{mask, w[11:8], w[7:0], lv});
        @(negedge clk);
        mode = m; pc = p; level = lv; inst_valid = 1;
        for (int n = 1; n <= 60 && done_n < 0; n++) begin
            @(negedge clk);
            inst_valid = 0;
            unit_done = '0;
            if (n == 1) check("rom_addr", 32'(rom_addr), 32'({m, p}));
            if (unit_start != 0) begin
                starts++;
                start_n = n;
                if (sb_q.size() == 0) check("start_unexpected", 32'(unit_start), 0);
                else begin
                    e = sb_q.pop_front();
                    check("start_mask", 32'(unit_start), 32'(e.mask));
                    check("start_op", 32'(unit_op), 32'(e.op));
                    check("start_arg", 32'(unit_arg), 32'(e.arg));
                    check("start_level", 32'(unit_level), 32'(e.lv));
                end
            end
            if (start_n > 0 && (unit_op !== w[11:8] || unit_arg !== w[7:0] || unit_level !== lv)) stable = 0;
            if (inst_done) done_n = n;
            if (start_n > 0 && n == start_n && lost) unit_done = mask;
            if (start_n > 0 && n == start_n + 1 && dly > 0) unit_done = ~mask;
            if (start_n > 0 && dly >= 0 && n == start_n + 1 + dly) unit_done = mask;
            if (mid_req && start_n > 0 && n == start_n + 2) begin
                inst_valid = 1;
                pc = p + 8'd1;
            end
        end
        unit_done = '0;
        if (exp_starts == 1) check("start_cycle", start_n, 3);
        check("start_count", starts, exp_starts);
        check("done_cycle", done_n, exp_done_n);
        check("fields_stable", 32'(stable), 1);
        check("sb_empty", sb_q.size(), 0);
        check("rom_addr_hold", 32'(rom_addr), 32'({m, p}));
        @(negedge clk);
        check("done_single", 32'(inst_done), 0);
        check("idle_after", 32'(busy), 0);
    endtask
    initial begin
        #400000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
    initial begin
        int dones;
        repeat (3) @(negedge clk);
        check("rst_start", 32'(unit_start), 0);
        check("rst_rom_addr", 32'(rom_addr), 0);
        check("rst_op", 32'(unit_op), 0);
        check("rst_arg", 32'(unit_arg), 0);
        check("rst_level", 32'(unit_level), 0);
        check("rst_done", 32'(inst_done), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_err", 32'(err), 0);
        rstn = 1;
        run_inst(MODE_ENCAP, 8'h05, 2'd2, 16'h132A, 0, 0, 0, 5);
        check("basic_err", 32'(err), 0);
        run_inst(MODE_DECAP, 8'h7E, 2'd1, {UNIT_SAMPLER, 4'h5, 8'hC3}, 20, 0, 1, 25);
        check("slow_err", 32'(err), 0);
        run_inst(MODE_KEYGEN, 8'h10, 2'd3, 16'hF000, 0, 0, 0, 3);
        check("nop_err", 32'(err), 0);
        run_inst(MODE_ENCAP, 8'hA0, 2'd0, {UNIT_PACK, 4'h9, 8'h44}, 10, 1, 0, 15);
        check("midreq_err", 32'(err), 32'd1);
        rstn = 0;
        @(negedge clk);
        rstn = 1;
        check("rst_clears_err", 32'(err), 0);
        run_inst(MODE_ENCAP, 8'h22, 2'd1, 16'h7000, 0, 0, 0, 3);
        check("badid_err", 32'(err), 32'd1);
        run_inst(MODE_KEYGEN, 8'hFF, 2'd2, {UNIT_MATMUL, 4'hE, 8'h01}, 2, 0, 0, 7);
        check("err_sticky", 32'(err), 32'd1);
        rstn = 0;
        @(negedge clk);
        rstn = 1;
        rom_word = {UNIT_SHAKE, 4'h1, 8'h10};
        rom_addr_exp = {MODE_KEYGEN, 8'h33};
        mode = MODE_KEYGEN; pc = 8'h33; level = 2'd1; inst_valid = 1;
        repeat (5) @(negedge clk) inst_valid = 0;
        check("wait_busy", 32'(busy), 1);
        rstn = 0;
        #1;
        check("rst_wait_busy", 32'(busy), 0);
        dones = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (inst_done) dones++;
            if (n == 2) rstn = 1;
        end
        check("rst_no_done", dones, 0);
        check("rst_wait_idle", 32'(busy), 0);
`ifdef DISPATCH_WDT_EN
        run_inst(MODE_ENCAP, 8'h40, 2'd0, {UNIT_SHAKE, 4'h2, 8'h20}, -1, 0, 0, 3 + 1 + WDT);
        check("wdt_err", 32'(err), 32'd2);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
